// File: rtl/ts_cc_pattern_gen.sv
// Transmit-side TS test source: framed bursts of header bytes followed by
// 188-byte TS packets carrying a fixed PID and a per-packet continuity counter.
// inject_err forces a single +2 CC step so downstream checkers see one discontinuity.
module ts_cc_pattern_gen #(
    parameter int unsigned HDR_LEN      = 6,
    parameter int unsigned TS_PER_FRAME = 7,
    parameter logic [12:0] PID          = 13'h1386,
    parameter int unsigned GAP_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        inject_err,
    output logic [7:0]  data_out,
    output logic        data_out_en,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam logic [5:0] HdrLast  = 6'(HDR_LEN - 1);
    localparam logic [3:0] PktLast  = 4'(TS_PER_FRAME - 1);
    localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] ByteLast = 8'd187;
    localparam logic [7:0] HdrBase  = 8'hA0;
    localparam logic [7:0] SyncByte = 8'h47;

    typedef enum logic [1:0] {StIdle, StHdr, StTs, StGap} state_e;

    state_e     state;
    logic [5:0] hdr_idx;
    logic [7:0] byte_idx;
    logic [3:0] pkt_idx;
    logic [7:0] gap_cnt;
    logic [3:0] cc;
    logic       err_pend;
    logic [3:0] cc_step;

    // Byte at position idx of a TS packet carrying continuity counter c
    function automatic logic [7:0] ts_byte(input logic [7:0] idx, input logic [3:0] c);
        case (idx)
            8'd0:    return SyncByte;
            8'd1:    return {3'b000, PID[12:8]};
            8'd2:    return PID[7:0];
            8'd3:    return {4'b0001, c};
            default: return idx;
        endcase
    endfunction

    // A pending or same-cycle error request turns the next CC advance into +2
    always_comb begin
        cc_step = (err_pend || inject_err) ? 4'd2 : 4'd1;
    end

    // Burst sequencer: every output is registered and reflects the byte being sent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            hdr_idx     <= '0;
            byte_idx    <= '0;
            pkt_idx     <= '0;
            gap_cnt     <= '0;
            cc          <= '0;
            err_pend    <= 1'b0;
            data_out    <= '0;
            data_out_en <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            // Sticky request; cleared below when a CC advance consumes it
            if (inject_err) begin
                err_pend <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (enable) begin
                        state       <= StHdr;
                        hdr_idx     <= '0;
                        data_out    <= HdrBase;
                        data_out_en <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                StHdr: begin
                    if (hdr_idx == HdrLast) begin
                        state    <= StTs;
                        pkt_idx  <= '0;
                        byte_idx <= '0;
                        data_out <= SyncByte;
                    end else begin
                        hdr_idx  <= hdr_idx + 6'd1;
                        data_out <= HdrBase + {2'b00, hdr_idx + 6'd1};
                    end
                end

                StTs: begin
                    if (byte_idx == ByteLast) begin
                        cc       <= cc + cc_step;
                        err_pend <= 1'b0;
                        if (pkt_idx == PktLast) begin
                            state       <= StGap;
                            gap_cnt     <= '0;
                            data_out    <= '0;
                            data_out_en <= 1'b0;
                            frame_cnt   <= frame_cnt + 16'd1;
                        end else begin
                            pkt_idx  <= pkt_idx + 4'd1;
                            byte_idx <= '0;
                            data_out <= SyncByte;
                        end
                    end else begin
                        byte_idx <= byte_idx + 8'd1;
                        data_out <= ts_byte(byte_idx + 8'd1, cc);
                    end
                end

                StGap: begin
                    if (gap_cnt == GapLast) begin
                        // enable is only sampled here, so a dropped enable finishes the burst
                        if (enable) begin
                            state       <= StHdr;
                            hdr_idx     <= '0;
                            data_out    <= HdrBase;
                            data_out_en <= 1'b1;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ts_cc_pattern_gen.sv
// Directed bench for ts_cc_pattern_gen: a vector table for the first bytes after
// enable, then whole-frame sequences covering CC wrap, error injection, enable
// drop and asynchronous reset.
module tb_ts_cc_pattern_gen;

    localparam int HDR = 6;
    localparam int NPKT = 7;
    localparam int GAP = 16;
    localparam int FRAME_EN = HDR + 188 * NPKT;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        inject_err;
    logic [7:0]  data_out;
    logic        data_out_en;
    logic        busy;
    logic [15:0] frame_cnt;

    int n_pass;
    int n_total;

    logic [3:0] ccs [NPKT];

    typedef struct {
        logic       enable;
        logic       inject;
        logic [7:0] data;
        logic       en;
        logic       busy;
    } vec_t;

    vec_t vecs [12];

    ts_cc_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .inject_err (inject_err),
        .data_out   (data_out),
        .data_out_en(data_out_en),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Runs one burst starting from the edge that emits header byte 0.
    task automatic run_frame(input string tag, input int inj_pkt, input int inj_byte,
                             input int drop_pkt, input int drop_byte,
                             input logic [15:0] fc_exp, input logic idle_after);
        int bad;
        int en_cnt;
        int gap_bad;
        logic [7:0] exp_b;
        bad = 0;
        en_cnt = 0;
        gap_bad = 0;
        for (int i = 0; i < HDR; i++) begin
            step();
            if (data_out_en) en_cnt++;
            exp_b = 8'hA0 + 8'(i);
            if (data_out !== exp_b || busy !== 1'b1) bad++;
        end
        for (int p = 0; p < NPKT; p++) begin
            for (int b = 0; b < 188; b++) begin
                step();
                if (data_out_en) en_cnt++;
                if (b == 3) begin
                    chk($sformatf("%s pkt%0d cc byte", tag, p), {24'h0, data_out},
                        {24'h0, 4'h1, ccs[p]});
                end else begin
                    case (b)
                        0: exp_b = 8'h47;
                        1: exp_b = 8'h13;
                        2: exp_b = 8'h86;
                        default: exp_b = 8'(b);
                    endcase
                    if (data_out !== exp_b || busy !== 1'b1) bad++;
                end
                inject_err = (p == inj_pkt && b == inj_byte);
                if (p == drop_pkt && b == drop_byte) enable = 1'b0;
            end
        end
        chk({tag, " payload/header bytes"}, bad, 0);
        chk({tag, " en cycles"}, en_cnt, FRAME_EN);
        for (int g = 0; g < GAP; g++) begin
            step();
            inject_err = 1'b0;
            if (g == 0) chk({tag, " frame_cnt"}, {16'h0, frame_cnt}, {16'h0, fc_exp});
            if (data_out_en !== 1'b0 || data_out !== 8'h00 || busy !== 1'b1) gap_bad++;
        end
        chk({tag, " gap cycles"}, gap_bad, 0);
        if (idle_after) begin
            step();
            chk({tag, " idle en"}, {31'h0, data_out_en}, 0);
            chk({tag, " idle busy"}, {31'h0, busy}, 0);
            step();
            chk({tag, " stays idle"}, {31'h0, data_out_en | busy}, 0);
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        enable = 1'b0;
        inject_err = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 8'hA0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 8'hA2, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 8'hA4, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 8'h47, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 8'h13, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 8'h86, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 8'h10, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h04, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 8'h05, 1'b1, 1'b1};

        repeat (3) step();
        chk("reset data_out", {24'h0, data_out}, 0);
        chk("reset en", {31'h0, data_out_en}, 0);
        chk("reset busy", {31'h0, busy}, 0);
        chk("reset frame_cnt", {16'h0, frame_cnt}, 0);

        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            enable = vecs[i].enable;
            inject_err = vecs[i].inject;
            step();
            chk($sformatf("vec%0d data", i), {24'h0, data_out}, {24'h0, vecs[i].data});
            chk($sformatf("vec%0d en", i), {31'h0, data_out_en}, {31'h0, vecs[i].en});
            chk($sformatf("vec%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].busy});
        end

        // Abandon this burst and start the frame sequences from a clean reset
        rst = 1'b1;
        enable = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle after reset busy", {31'h0, busy}, 0);

        enable = 1'b1;
        ccs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        run_frame("f1", -1, -1, -1, -1, 16'd1, 1'b0);
        ccs = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
        run_frame("f2", -1, -1, -1, -1, 16'd2, 1'b0);
        ccs = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        run_frame("f3", -1, -1, -1, -1, 16'd3, 1'b0);
        // Error requested mid-packet while cc=5
        ccs = '{4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
        run_frame("f4", 0, 100, -1, -1, 16'd4, 1'b0);
        // Error requested on the byte-187 cycle of the cc=3 packet
        ccs = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3};
        run_frame("f5", 6, 187, -1, -1, 16'd5, 1'b0);
        // Enable dropped at packet 2 byte 50
        ccs = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        run_frame("f6", -1, -1, 2, 50, 16'd6, 1'b1);

        // Asynchronous reset in the middle of packet 0
        enable = 1'b1;
        repeat (HDR + 60) step();
        chk("pre-reset en", {31'h0, data_out_en}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst en", {31'h0, data_out_en}, 0);
        chk("async rst data", {24'h0, data_out}, 0);
        chk("async rst busy", {31'h0, busy}, 0);
        chk("async rst frame_cnt", {16'h0, frame_cnt}, 0);
        step();
        rst = 1'b0;
        ccs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        run_frame("post-rst", -1, -1, 0, 0, 16'd1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
